// File: rtl/tmr_voter_pkg.sv
// Shared constants for the TMR word voter: error_cba bit positions and
// the flag pattern reported when no two replicas agree.
package tmr_voter_pkg;

    // Bit positions inside error_cba, one per replica lane.
    localparam int ErrA = 0;
    localparam int ErrB = 1;
    localparam int ErrC = 2;

    // Flag patterns for the two extremes of the vote.
    localparam logic [2:0] ErrNone = 3'b000;
    localparam logic [2:0] ErrAll  = 3'b111;

endpackage : tmr_voter_pkg

// File: rtl/tmr_word_vote_core.sv
// Combinational whole-word 2-of-3 vote. Replicas are compared as complete
// words, not bit by bit. When no two replicas agree, lane a is passed through
// and the uncorrectable flag is raised.
module tmr_word_vote_core
    import tmr_voter_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [DataWidth-1:0] in_a,
    input  logic [DataWidth-1:0] in_b,
    input  logic [DataWidth-1:0] in_c,
    output logic [DataWidth-1:0] vote,
    output logic                 error,
    output logic [2:0]           error_cba
);

    logic eq_ab;
    logic eq_bc;
    logic eq_ac;

    assign eq_ab = (in_a == in_b);
    assign eq_bc = (in_b == in_c);
    assign eq_ac = (in_a == in_c);

    // Select the majority word and flag the single lane that disagrees.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        vote      = in_a;
        error     = 1'b0;
        error_cba = ErrNone;

        if (eq_ab && eq_bc) begin
            vote = in_a;
        end else if (eq_bc) begin
            vote            = in_b;
            error_cba[ErrA] = 1'b1;
        end else if (eq_ac) begin
            vote            = in_a;
            error_cba[ErrB] = 1'b1;
        end else if (eq_ab) begin
            vote            = in_a;
            error_cba[ErrC] = 1'b1;
        end else begin
            vote      = in_a;
            error     = 1'b1;
            error_cba = ErrAll;
        end
    end

endmodule : tmr_word_vote_core

// File: rtl/tmr_word_voter.sv
// Registered TMR word voter: one-cycle-latency wrapper around
// tmr_word_vote_core. Defining TMR_VOTER_FAULT_CNT_EN adds per-lane
// saturating fault counters, the cnt_clr_i input and the fault_cnt_a/b/c
// outputs.
module tmr_word_voter
    import tmr_voter_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] in_a,
    input  logic [DataWidth-1:0] in_b,
    input  logic [DataWidth-1:0] in_c,
`ifdef TMR_VOTER_FAULT_CNT_EN
    input  logic                 cnt_clr_i,
    output logic [CntWidth-1:0]  fault_cnt_a,
    output logic [CntWidth-1:0]  fault_cnt_b,
    output logic [CntWidth-1:0]  fault_cnt_c,
`endif
    output logic [DataWidth-1:0] out,
    output logic                 error,
    output logic [2:0]           error_cba
);

    logic [DataWidth-1:0] vote_d;
    logic                 error_d;
    logic [2:0]           error_cba_d;

    tmr_word_vote_core #(
        .DataWidth (DataWidth)
    ) u_core (
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .vote      (vote_d),
        .error     (error_d),
        .error_cba (error_cba_d)
    );

    // Output register: a new vote every cycle, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out       <= '0;
            error     <= 1'b0;
            error_cba <= ErrNone;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from values sampled at the edge.
            out       <= vote_d;
            error     <= error_d;
            error_cba <= error_cba_d;
        end
    end

`ifdef TMR_VOTER_FAULT_CNT_EN
    logic [CntWidth-1:0] fault_cnt [3];

    // Per-lane fault counters are driven by the registered flags. They
    // saturate at all-ones, and a clear has priority over an increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 3; i++) begin
                fault_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cnt_clr_i) begin
                    fault_cnt[i] <= '0;
                end else if (error_cba[i] && (fault_cnt[i] != '1)) begin
                    fault_cnt[i] <= fault_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign fault_cnt_a = fault_cnt[ErrA];
    assign fault_cnt_b = fault_cnt[ErrB];
    assign fault_cnt_c = fault_cnt[ErrC];
`endif

endmodule : tmr_word_voter

// File: tb/tb_tmr_word_voter.sv
// Directed and randomised self-checking bench for tmr_word_voter. It covers
// the default build, and also the counter build when TMR_VOTER_FAULT_CNT_EN
// is defined.
module tb_tmr_word_voter;

    localparam int DW    = 32;
    localparam int CNT_W = 2;

    logic          clk_i;
    logic          rst_ni;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] in_c;
    logic [DW-1:0] out;
    logic          error;
    logic [2:0]    error_cba;
`ifdef TMR_VOTER_FAULT_CNT_EN
    logic             cnt_clr_i;
    logic [CNT_W-1:0] fault_cnt_a;
    logic [CNT_W-1:0] fault_cnt_b;
    logic [CNT_W-1:0] fault_cnt_c;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    tmr_word_voter #(
        .DataWidth (DW),
        .CntWidth  (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_c        (in_c),
`ifdef TMR_VOTER_FAULT_CNT_EN
        .cnt_clr_i   (cnt_clr_i),
        .fault_cnt_a (fault_cnt_a),
        .fault_cnt_b (fault_cnt_b),
        .fault_cnt_c (fault_cnt_c),
`endif
        .out         (out),
        .error       (error),
        .error_cba   (error_cba)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        in_a = a;
        in_b = b;
        in_c = c;
    endtask

    // Wait one rising edge, then sample the registered outputs 1 ns later.
    task automatic expect_vote(input string tag, input logic [DW-1:0] e_out,
                               input logic e_err, input logic [2:0] e_cba);
        @(posedge clk_i);
        #1;
        check({tag, ".out"}, 64'(out), 64'(e_out));
        check({tag, ".err"}, 64'(error), 64'(e_err));
        check({tag, ".cba"}, 64'(error_cba), 64'(e_cba));
    endtask

    initial begin
        logic [DW-1:0] base;
        logic [DW-1:0] bad;
        logic [DW-1:0] prev_out;
        logic [DW-1:0] e_out;
        logic [2:0]    e_cba;

        rst_ni = 1'b0;
        drive(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
`ifdef TMR_VOTER_FAULT_CNT_EN
        cnt_clr_i = 1'b0;
`endif

        // Outputs stay at zero while reset is held, even as the clock runs.
        repeat (2) @(posedge clk_i);
        #1;
        check("rst.out", 64'(out), 64'h0);
        check("rst.err", 64'(error), 64'h0);
        check("rst.cba", 64'(error_cba), 64'h0);

        // The first vote after reset release is registered one edge later.
        drive(32'h12345678, 32'h12345678, 32'h12345678);
        @(negedge clk_i);
        rst_ni = 1'b1;
        expect_vote("equal", 32'h12345678, 1'b0, 3'b000);

        // Single-lane corruption of each replica in turn.
        drive(32'hFFFF0000, 32'h0000FFFF, 32'h0000FFFF);
        expect_vote("bad_a", 32'h0000FFFF, 1'b0, 3'b001);
        drive(32'h0000FFFF, 32'hFFFF0000, 32'h0000FFFF);
        expect_vote("bad_b", 32'h0000FFFF, 1'b0, 3'b010);
        drive(32'h0000FFFF, 32'h0000FFFF, 32'hFFFF0000);
        expect_vote("bad_c", 32'h0000FFFF, 1'b0, 3'b100);

        // When all three replicas differ, lane a passes through and the vote is uncorrectable.
        drive(32'd1, 32'd2, 32'd3);
        expect_vote("all_diff", 32'd1, 1'b1, 3'b111);

        // Random sweeps: case 0 keeps all lanes equal, cases 1..3 corrupt lane a, b or c.
        // Before each edge the output must still show the previous vote.
        prev_out = 32'd1;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 10000; n++) begin
                base = $urandom;
                bad  = $urandom;
                if (bad == base) bad = base ^ 32'h1;
                case (k)
                    1:       begin drive(bad, base, base); e_cba = 3'b001; end
                    2:       begin drive(base, bad, base); e_cba = 3'b010; end
                    3:       begin drive(base, base, bad); e_cba = 3'b100; end
                    default: begin drive(base, base, base); e_cba = 3'b000; end
                endcase
                e_out = base;
                #1;
                check("rnd.hold", 64'(out), 64'(prev_out));
                expect_vote("rnd", e_out, 1'b0, e_cba);
                prev_out = e_out;
            end
        end

        // Reset asserted between edges clears the outputs without waiting for a clock.
        drive(32'd1, 32'd2, 32'd3);
        expect_vote("pre_rst", 32'd1, 1'b1, 3'b111);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst.out", 64'(out), 64'h0);
        check("arst.err", 64'(error), 64'h0);
        check("arst.cba", 64'(error_cba), 64'h0);
        drive(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        @(negedge clk_i);
        rst_ni = 1'b1;
        expect_vote("post_rst", 32'hA5A5A5A5, 1'b0, 3'b000);

`ifdef TMR_VOTER_FAULT_CNT_EN
        check("cnt.rst_a", 64'(fault_cnt_a), 64'h0);
        check("cnt.rst_c", 64'(fault_cnt_c), 64'h0);
        // Corrupting lane c for five cycles drives the 2-bit counter to saturation.
        drive(32'h0, 32'h0, 32'h1);
        repeat (5) @(posedge clk_i);
        #1;
        drive(32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk_i);
        #1;
        check("cnt.sat_c", 64'(fault_cnt_c), 64'h3);
        check("cnt.a", 64'(fault_cnt_a), 64'h0);
        check("cnt.b", 64'(fault_cnt_b), 64'h0);
        cnt_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        cnt_clr_i = 1'b0;
        check("cnt.clr_c", 64'(fault_cnt_c), 64'h0);
        check("cnt.clr_a", 64'(fault_cnt_a), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tmr_word_voter
